// File: rtl/sb_pkg.sv
// Shared types, funct3 encodings and the load byte/half extraction helper for
// the store buffer.
//
// Contents:
//   SbAddrW       - address width stored in each entry (store_buffer AW must not exceed it)
//   Ld*/St*       - funct3 encodings for loads and stores
//   sb_entry_t    - one buffered store: {st_type, addr, data}
//   load_extract  - byte/half selection plus sign/zero extension of a 32-bit word
package sb_pkg;

    localparam int unsigned SbAddrW = 32;

    localparam logic [2:0] LdLb  = 3'b000;
    localparam logic [2:0] LdLh  = 3'b001;
    localparam logic [2:0] LdLw  = 3'b010;
    localparam logic [2:0] LdLbu = 3'b100;
    localparam logic [2:0] LdLhu = 3'b101;

    localparam logic [2:0] StSb = 3'b000;
    localparam logic [2:0] StSh = 3'b001;
    localparam logic [2:0] StSw = 3'b010;

    typedef struct packed {
        logic [2:0]         st_type;
        logic [SbAddrW-1:0] addr;
        logic [31:0]        data;
    } sb_entry_t;

    // Select the addressed byte/half of a word and extend it as the load type asks.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  ld_type,
                                                 input logic [1:0]  offset);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (ld_type)
            LdLb:    result = {{24{shifted[7]}}, shifted[7:0]};
            LdLh:    result = {{16{shifted[15]}}, shifted[15:0]};
            LdLbu:   result = {24'b0, shifted[7:0]};
            LdLhu:   result = {16'b0, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core/memory side signal bundle of the store buffer.
//
// Parameters: AW - address width.
// Modports:
//   slave  - the store buffer: takes the core request, drives the memory port,
//            stall, sb_empty and the forwarding result.
//   master - the core/memory environment around it.
interface store_buffer_if #(
    parameter int unsigned AW = 32
) ();
    // Core request
    logic          cpu_st_valid;
    logic          cpu_ld_valid;
    logic [2:0]    cpu_st_type;
    logic [2:0]    cpu_ld_type;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    // Core status
    logic          stall;
    logic          sb_empty;
    // Memory port
    logic          d_wr_en;
    logic [2:0]    store_type;
    logic [2:0]    load_type;
    logic [AW-1:0] dAddr;
    logic [31:0]   dWdata;
    // Store-to-load forwarding result
    logic          fwd_valid;
    logic [31:0]   fwd_data;

    modport slave (
        input  cpu_st_valid, cpu_ld_valid, cpu_st_type, cpu_ld_type, cpu_addr, cpu_wdata,
        output stall, sb_empty, d_wr_en, store_type, load_type, dAddr, dWdata,
        output fwd_valid, fwd_data
    );

    modport master (
        output cpu_st_valid, cpu_ld_valid, cpu_st_type, cpu_ld_type, cpu_addr, cpu_wdata,
        input  stall, sb_empty, d_wr_en, store_type, load_type, dAddr, dWdata,
        input  fwd_valid, fwd_data
    );
endinterface

// File: rtl/sb_fifo.sv
// Circular storage for the store buffer: entry array, write/read pointers and
// occupancy count. Full/empty come from the count only.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers and count only)
//   push        - write push_entry at the tail this cycle
//   push_entry  - entry to enqueue
//   pop         - retire the head entry this cycle (caller guarantees count > 0)
//   head        - oldest entry
//   entries     - whole entry array, indexed by slot
//   valid       - per-slot occupancy
//   count       - number of occupied entries
//   rd_ptr      - slot index of the head (lets callers walk slots in age order)
//   full, empty - occupancy flags
module sb_fifo
    import sb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH) + 1,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head,
    output sb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PW-1:0]    count,
    output logic [PW-1:0]    rd_ptr,
    output logic             full,
    output logic             empty
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    sb_entry_t     mem_q [DEPTH];
    logic [IW-1:0] age;

    // Pointers stay within 0..DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset: only slots covered by count are ever used.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[IW-1:0]] <= push_entry;
    end

    // A slot is live when its distance from the head is below count.
    always_comb begin
        valid = '0;
        age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = IW'(i) - rd_ptr_q[IW-1:0];
            valid[i] = PW'(age) < count_q;
        end
    end

    assign entries = mem_q;
    assign head    = mem_q[rd_ptr_q[IW-1:0]];
    assign count   = count_q;
    assign rd_ptr  = rd_ptr_q;
    assign full    = (count_q == PW'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core's execute stage and a single-port data memory
// (shared address, combinational read, posedge write). Stores retire into the
// buffer in one cycle and drain in program order whenever a load does not own
// the port. A load hitting a pending store's word stalls until it has drained.
//
// Optional feature, macro STORE_FWD_EN: a load whose youngest matching entry is
// an SW is served from that entry (fwd_valid/fwd_data) without stalling, and the
// head drains in the same cycle. Undefined: fwd_valid and fwd_data are tied 0.
//
// Parameters: DEPTH (power of 2, >= 2), AW (address width, <= sb_pkg::SbAddrW).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - store_buffer_if.slave: core request, stall/sb_empty, memory
//                port (d_wr_en, store_type, load_type, dAddr, dWdata), forwarding
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = $clog2(DEPTH);

    sb_entry_t        head;
    sb_entry_t        entries [DEPTH];
    sb_entry_t        push_entry;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic [PW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             drain;
    logic             hit;
    logic             fwd_ok;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (head),
        .entries    (entries),
        .valid      (valid),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .full       (full),
        .empty      (empty)
    );

    assign push_entry = '{st_type: bus.cpu_st_type,
                          addr:    SbAddrW'(bus.cpu_addr),
                          data:    bus.cpu_wdata};

    // Word-granular hazard compare; the byte offset is ignored.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (entries[i].addr[AW-1:2] == bus.cpu_addr[AW-1:2]);
        end
    end

    assign hit = bus.cpu_ld_valid && (|match);

`ifdef STORE_FWD_EN
    sb_entry_t     youngest;
    logic [IW-1:0] slot;

    // Walk slots oldest to youngest so the last match seen is the youngest.
    always_comb begin
        youngest = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr[IW-1:0] + IW'(k);
            if (match[slot]) youngest = entries[slot];
        end
    end

    // A full-word store covers every byte the load can want.
    assign fwd_ok       = hit && (youngest.st_type == StSw);
    assign bus.fwd_valid = fwd_ok;
    assign bus.fwd_data  = fwd_ok ?
                           load_extract(youngest.data, bus.cpu_ld_type, bus.cpu_addr[1:0]) :
                           32'h0;
`else
    logic unused_rd_ptr;

    assign fwd_ok        = 1'b0;
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_data  = 32'h0;
    assign unused_rd_ptr = ^rd_ptr;
`endif

    // Port arbitration: a non-hitting load owns the port; otherwise the head drains.
    always_comb begin
        drain          = 1'b0;
        bus.stall      = 1'b0;
        bus.d_wr_en    = 1'b0;
        bus.dAddr      = '0;
        bus.dWdata     = '0;
        bus.store_type = '0;
        bus.load_type  = LdLw;

        if (bus.cpu_ld_valid && !hit) begin
            bus.dAddr     = bus.cpu_addr;
            bus.load_type = bus.cpu_ld_type;
        end else if (bus.cpu_ld_valid) begin
            drain     = 1'b1;
            bus.stall = !fwd_ok;
        end else if (!empty) begin
            drain = 1'b1;
        end

        if (drain) begin
            bus.d_wr_en    = 1'b1;
            bus.dAddr      = head.addr[AW-1:0];
            bus.dWdata     = head.data;
            bus.store_type = head.st_type;
        end

        // A draining cycle frees a slot, so a full buffer can still accept.
        push = bus.cpu_st_valid && (!full || drain);
        if (bus.cpu_st_valid && full && !drain) bus.stall = 1'b1;
    end

    assign bus.sb_empty = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, two hand-written
// multi-cycle sequences and a randomized run against a queue-based model with
// an architectural byte memory.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic clk;
    logic rst_n;
    logic mem_clear;

    store_buffer_if #(.AW(AW)) bus ();

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory behind the DUT port.
    logic [7:0] phys [256];
    // Program-order memory image: every accepted store applied immediately.
    logic [7:0] arch [256];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) phys[i] <= 8'h0;
        end else if (rst_n && bus.d_wr_en) begin
            phys[bus.dAddr[7:0]] <= bus.dWdata[7:0];
            if (bus.store_type != SB) phys[bus.dAddr[7:0] + 8'd1] <= bus.dWdata[15:8];
            if (bus.store_type == SW) begin
                phys[bus.dAddr[7:0] + 8'd2] <= bus.dWdata[23:16];
                phys[bus.dAddr[7:0] + 8'd3] <= bus.dWdata[31:24];
            end
        end
    end

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
    } st_rec_t;

    st_rec_t sbq [$];

    int checks;
    int errors;
    logic [31:0] last_ld;

    function automatic logic [31:0] mem_read(input logic [7:0] m [256], input logic [7:0] a,
                                             input logic [2:0] t);
        logic [31:0] w;
        w = {m[a + 8'd3], m[a + 8'd2], m[a + 8'd1], m[a]};
        case (t)
            LB:      return {{24{w[7]}}, w[7:0]};
            LH:      return {{16{w[15]}}, w[15:0]};
            LBU:     return {24'h0, w[7:0]};
            LHU:     return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic arch_write(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        arch[a[7:0]] = d[7:0];
        if (t != SB) arch[a[7:0] + 8'd1] = d[15:8];
        if (t == SW) begin
            arch[a[7:0] + 8'd2] = d[23:16];
            arch[a[7:0] + 8'd3] = d[31:24];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One core cycle: drive at negedge, compare against the model, commit the model.
    task automatic step(input logic st, input logic ld, input logic [2:0] stt,
                        input logic [2:0] ldt, input logic [31:0] addr, input logic [31:0] wd,
                        output logic stalled);
        logic hit, fwd, drain, accept;
        logic e_stall, e_wr;
        logic [31:0] e_addr, e_wdata, got;
        logic [2:0] e_stt, e_ldt;
        int y;
        @(negedge clk);
        bus.cpu_st_valid = st;
        bus.cpu_ld_valid = ld;
        bus.cpu_st_type  = stt;
        bus.cpu_ld_type  = ldt;
        bus.cpu_addr     = addr;
        bus.cpu_wdata    = wd;
        #1;
        hit = 1'b0;
        y   = -1;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (ld && sbq[i].a[31:2] == addr[31:2] && y < 0) begin
                hit = 1'b1;
                y   = i;
            end
        end
        fwd = 1'b0;
`ifdef STORE_FWD_EN
        if (hit) fwd = (sbq[y].t == SW);
`endif
        e_stall = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
        e_stt = 3'd0; e_ldt = LW; drain = 1'b0;
        if (ld && !hit) begin
            e_addr = addr;
            e_ldt  = ldt;
        end else if (ld) begin
            drain   = 1'b1;
            e_stall = !fwd;
        end else if (sbq.size() > 0) begin
            drain = 1'b1;
        end
        if (drain) begin
            e_wr    = 1'b1;
            e_addr  = sbq[0].a;
            e_wdata = sbq[0].d;
            e_stt   = sbq[0].t;
        end
        accept = st && (sbq.size() < DEPTH || drain);
        if (st && !accept) e_stall = 1'b1;

        chk("stall", bus.stall, e_stall);
        chk("d_wr_en", bus.d_wr_en, e_wr);
        chk("dAddr", bus.dAddr, e_addr);
        chk("dWdata", bus.dWdata, e_wdata);
        chk("store_type", bus.store_type, e_stt);
        chk("load_type", bus.load_type, e_ldt);
        chk("sb_empty", bus.sb_empty, sbq.size() == 0);
        chk("fwd_valid", bus.fwd_valid, fwd);
        if (ld && !e_stall) begin
            got = bus.fwd_valid ? bus.fwd_data :
                                  mem_read(phys, bus.dAddr[7:0], bus.load_type);
            last_ld = got;
            chk("load_data", got, mem_read(arch, addr[7:0], ldt));
        end
        if (drain) void'(sbq.pop_front());
        if (accept) begin
            sbq.push_back('{t: stt, a: addr, d: wd});
            arch_write(stt, addr, wd);
        end
        stalled = e_stall;
    endtask

    typedef struct {
        logic        st, ld;
        logic [2:0]  stt, ldt;
        logic [31:0] addr, wd;
        logic        e_stall, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic        e_empty;
        logic [2:0]  e_ldt;
        logic        e_ld_chk;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic s;
        logic hold;
        int   stall_run;
        logic r_st, r_ld;
        logic [2:0] r_stt, r_ldt;
        logic [31:0] r_addr, r_wd;
        int op;

        checks = 0;
        errors = 0;
        last_ld = 32'h0;
        //            st    ld    stt ldt  addr    wdata         stl   wr    dAddr   dWdata        emp   ldt  ldchk  ld
        vecs[0]  = '{1'b0, 1'b0, SB, LB, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, LW,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, SW, LB, 32'h8,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, LW,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, SB, LB, 32'h0,  32'h0,        1'b0, 1'b1, 32'h8,  32'hDEADBEEF, 1'b0, LW,  1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, SB, LB, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, LW,  1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, SW, LB, 32'h0,  32'h11111111, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, LW,  1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, SW, LB, 32'h4,  32'h22222222, 1'b0, 1'b1, 32'h0,  32'h11111111, 1'b0, LW,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, SB, LW, 32'h10, 32'h0,        1'b0, 1'b0, 32'h10, 32'h0,        1'b0, LW,  1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, SB, LB, 32'h0,  32'h0,        1'b0, 1'b1, 32'h4,  32'h22222222, 1'b0, LW,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, SB, LB, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, LW,  1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, SB, LB, 32'h5,  32'h80,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1, LW,  1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, SB, LB, 32'h5,  32'h0,        1'b1, 1'b1, 32'h5,  32'h80,       1'b0, LW,  1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, SB, LB, 32'h5,  32'h0,        1'b0, 1'b0, 32'h5,  32'h0,        1'b1, LB,  1'b1, 32'hFFFFFF80};

        bus.cpu_st_valid = 1'b0;
        bus.cpu_ld_valid = 1'b0;
        bus.cpu_st_type  = 3'd0;
        bus.cpu_ld_type  = 3'd0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        for (int i = 0; i < 256; i++) arch[i] = 8'h0;
        rst_n     = 1'b0;
        mem_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_clear = 1'b0;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].st, vecs[i].ld, vecs[i].stt, vecs[i].ldt, vecs[i].addr, vecs[i].wd, s);
            chk($sformatf("vec%0d_stall", i), bus.stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_wr", i), bus.d_wr_en, vecs[i].e_wr);
            chk($sformatf("vec%0d_addr", i), bus.dAddr, vecs[i].e_addr);
            chk($sformatf("vec%0d_wdata", i), bus.dWdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d_empty", i), bus.sb_empty, vecs[i].e_empty);
            chk($sformatf("vec%0d_ldtype", i), bus.load_type, vecs[i].e_ldt);
            if (vecs[i].e_ld_chk) chk($sformatf("vec%0d_lddata", i), last_ld, vecs[i].e_ld);
        end

        // Back-to-back stores then a load hitting the youngest one
        step(1'b1, 1'b0, SW, LB, 32'h20, 32'hA0A0A0A0, s);
        step(1'b1, 1'b0, SW, LB, 32'h24, 32'h0B0B0B0B, s);
        step(1'b1, 1'b0, SW, LB, 32'h28, 32'h33445566, s);
        step(1'b0, 1'b1, SB, LW, 32'h28, 32'h0, s);
`ifdef STORE_FWD_EN
        chk("seqA_fwd_valid", bus.fwd_valid, 32'h1);
        chk("seqA_fwd_data", bus.fwd_data, 32'h33445566);
        chk("seqA_stall", bus.stall, 32'h0);
        chk("seqA_drain", bus.d_wr_en, 32'h1);
        step(1'b0, 1'b0, SB, LB, 32'h0, 32'h0, s);
`else
        chk("seqA_stall", bus.stall, 32'h1);
        chk("seqA_drain_addr", bus.dAddr, 32'h28);
        step(1'b0, 1'b1, SB, LW, 32'h28, 32'h0, s);
        chk("seqA_stall_released", bus.stall, 32'h0);
        chk("seqA_no_write", bus.d_wr_en, 32'h0);
        chk("seqA_load", last_ld, 32'h33445566);
`endif

        // Reset while a store is draining
        step(1'b1, 1'b0, SW, LB, 32'h30, 32'hCAFEF00D, s);
        @(negedge clk);
        bus.cpu_st_valid = 1'b0;
        bus.cpu_ld_valid = 1'b0;
        #1;
        chk("seqB_draining", bus.d_wr_en, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("seqB_rst_wr", bus.d_wr_en, 32'h0);
        chk("seqB_rst_empty", bus.sb_empty, 32'h1);
        chk("seqB_rst_stall", bus.stall, 32'h0);
        chk("seqB_rst_addr", bus.dAddr, 32'h0);
        chk("seqB_rst_ldtype", bus.load_type, LW);
        sbq.delete();
        arch = phys;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, SB, LW, 32'h30, 32'h0, s);
        chk("seqB_discarded", last_ld, 32'h0);

        // Randomized traffic; a stalled instruction is reissued unchanged.
        hold = 1'b0;
        stall_run = 0;
        r_st = 1'b0; r_ld = 1'b0; r_stt = SB; r_ldt = LB; r_addr = 32'h0; r_wd = 32'h0;
        for (int n = 0; n < 500; n++) begin
            if (!hold) begin
                op   = int'($urandom_range(0, 3));
                r_st = (op == 1) || (op == 3);
                r_ld = (op == 2);
                r_wd = $urandom;
                r_addr = 32'($urandom_range(0, 7)) * 4;
                case ($urandom_range(0, 2))
                    0:       begin r_stt = SB; end
                    1:       begin r_stt = SH; end
                    default: begin r_stt = SW; end
                endcase
                case ($urandom_range(0, 4))
                    0:       begin r_ldt = LB; end
                    1:       begin r_ldt = LH; end
                    2:       begin r_ldt = LW; end
                    3:       begin r_ldt = LBU; end
                    default: begin r_ldt = LHU; end
                endcase
                if (r_st && r_stt == SB) r_addr = r_addr + 32'($urandom_range(0, 3));
                if (r_st && r_stt == SH) r_addr = r_addr + 32'($urandom_range(0, 1)) * 2;
                if (r_ld && (r_ldt == LB || r_ldt == LBU)) r_addr = r_addr + 32'($urandom_range(0, 3));
                if (r_ld && (r_ldt == LH || r_ldt == LHU)) r_addr = r_addr + 32'($urandom_range(0, 1)) * 2;
            end
            step(r_st, r_ld, r_stt, r_ldt, r_addr, r_wd, s);
            if (s) begin
                hold = 1'b1;
                stall_run++;
                if (stall_run > DEPTH + 2) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_bound: stalled %0d cycles, limit %0d", stall_run, DEPTH + 2);
                    hold = 1'b0;
                    stall_run = 0;
                end
            end else begin
                hold = 1'b0;
                stall_run = 0;
            end
        end

        // Let everything drain, then confirm memory matches program order.
        repeat (DEPTH + 2) step(1'b0, 1'b0, SB, LB, 32'h0, 32'h0, s);
        for (int a = 0; a < 40; a += 4) begin
            step(1'b0, 1'b1, SB, LW, 32'(a), 32'h0, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
